// File: rtl/ps2_receiver.sv
// -----------------------------------------------------------------------------
// ps2_receiver
//
// Receive-only PS/2 keyboard deserialiser. Converts the device-clocked 11-bit
// frame (start, 8 data bits LSB first, odd parity, stop) into a scan-code byte
// with a one-cycle data_rdy strobe for the downstream matrix decoder.
//
// Signal path:
//   raw pins -> SYNC_STAGES-deep synchronisers -> ps2_clk glitch filter
//   -> falling-edge detect -> frame FSM -> registered byte and strobes
//
// Optional feature (compile-time macro PS2_TIMEOUT_EN):
//   When defined, a partial frame that sees no falling edge for
//   TIMEOUT_CYCLES clk cycles is abandoned and reported on frame_err.
//   When undefined, a partial frame waits indefinitely.
// -----------------------------------------------------------------------------
module ps2_receiver #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       data_rdy,
  output logic       parity_err,
  output logic       frame_err
);

  // Frame position. IDLE waits for a start bit; DATA collects eight bits;
  // PARITY and STOP each consume one bit.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Wide enough to hold FILTER_LEN itself.
  localparam int FCW = $clog2(FILTER_LEN + 1);

  // Synchronisers: bit 0 is the first stage, the MSB is the usable output.
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   sync_clk;
  logic                   sync_data;

  // Glitch filter.
  logic [FCW-1:0]         filt_cnt;
  logic                   clk_filt;
  logic                   filt_flip;
  logic                   fall_edge;

  // Frame FSM and datapath.
  state_t                 state;
  state_t                 state_next;
  logic [2:0]             bit_cnt;
  logic [7:0]             shift_reg;
  logic                   parity_bit;
  logic                   timeout_hit;

  // Strobe requests, registered into the outputs one cycle later.
  logic                   rdy_next;
  logic                   perr_next;
  logic                   ferr_next;

  assign sync_clk  = clk_sync[SYNC_STAGES-1];
  assign sync_data = data_sync[SYNC_STAGES-1];

  // Bring both asynchronous pins into the clk domain; idle level is high.
  // NOTE: clocked blocks use non-blocking assignments so every register in the
  // chain samples the value its neighbour held before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  // The filtered clock only follows the synchronised clock once it has
  // disagreed for FILTER_LEN consecutive samples; any agreement restarts the
  // count, so short spikes on the line never produce an edge.
  assign filt_flip = (sync_clk != clk_filt) && (filt_cnt == FCW'(FILTER_LEN - 1));

  // A 1->0 flip of the filtered clock is the sampling point for ps2_data.
  assign fall_edge = filt_flip && clk_filt;

  // Glitch filter counter and filtered clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_cnt <= '0;
      clk_filt <= 1'b1;
    end else if (sync_clk == clk_filt) begin
      filt_cnt <= '0;
    end else if (filt_flip) begin
      filt_cnt <= '0;
      clk_filt <= ~clk_filt;
    end else begin
      filt_cnt <= filt_cnt + FCW'(1);
    end
  end

`ifdef PS2_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TCW-1:0] to_cnt;

  // The count reaches TIMEOUT_CYCLES in the cycle it would step past
  // TIMEOUT_CYCLES-1. A falling edge in that same cycle does not rescue the
  // frame: the abort takes priority in the FSM.
  assign timeout_hit = (state != IDLE) && (to_cnt == TCW'(TIMEOUT_CYCLES - 1));

  // Count idle clk cycles between falling edges of a frame in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
    end else if ((state == IDLE) || fall_edge || timeout_hit) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TCW'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and strobe requests; the FSM only moves on a filtered falling
  // edge or a timeout.
  // NOTE: every output of this block is given a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    rdy_next   = 1'b0;
    perr_next  = 1'b0;
    ferr_next  = 1'b0;

    if (timeout_hit) begin
      state_next = IDLE;
      ferr_next  = 1'b1;
    end else if (fall_edge) begin
      unique case (state)
        IDLE: begin
          // A high sample in IDLE is just line noise or idle; ignore it.
          if (!sync_data) state_next = DATA;
        end
        DATA: begin
          if (bit_cnt == 3'd7) state_next = PARITY;
        end
        PARITY: begin
          state_next = STOP;
        end
        STOP: begin
          state_next = IDLE;
          // Stop-bit failure outranks parity failure; one strobe per frame.
          if (!sync_data) begin
            ferr_next = 1'b1;
          end else if ((^shift_reg) ^ parity_bit) begin
            rdy_next = 1'b1;
          end else begin
            perr_next = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Bit collection: shift LSB-first into bit 7, keep the parity bit aside.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt    <= 3'd0;
      shift_reg  <= 8'h00;
      parity_bit <= 1'b0;
    end else if (timeout_hit) begin
      bit_cnt <= 3'd0;
    end else if (fall_edge) begin
      unique case (state)
        IDLE: begin
          bit_cnt <= 3'd0;
        end
        DATA: begin
          shift_reg <= {sync_data, shift_reg[7:1]};
          bit_cnt   <= bit_cnt + 3'd1;
        end
        PARITY: begin
          parity_bit <= sync_data;
        end
        default: begin
          bit_cnt <= bit_cnt;
        end
      endcase
    end
  end

  // Registered outputs: strobes last exactly one cycle, data only changes on
  // a frame that passed both the stop-bit and parity checks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data       <= 8'h00;
      data_rdy   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_rdy   <= rdy_next;
      parity_err <= perr_next;
      frame_err  <= ferr_next;
      if (rdy_next) data <= shift_reg;
    end
  end

endmodule

// File: tb/tb_ps2_receiver.sv
// -----------------------------------------------------------------------------
// tb_ps2_receiver
//
// Directed-frame bench for ps2_receiver. A frame-level model predicts, from
// the byte, parity bit and stop bit alone, which strobe each frame must raise
// and what data must read afterwards; a compare process checks the DUT
// against that prediction on every clk cycle. Literal checks after each
// scenario pin the model to hand-computed values.
//
// clk is treated as a 960 kHz clock, so a 12 kHz PS/2 clock is 80 clk cycles
// per bit (HALF = 40 cycles high, 40 low). Build with +define+PS2_TIMEOUT_EN
// to include the timeout scenario.
// -----------------------------------------------------------------------------
module tb_ps2_receiver;

  localparam int SYNC_STAGES = 2;
  localparam int FILTER_LEN  = 8;
  localparam int TB_TIMEOUT  = 600;
  localparam int HALF        = 40;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] data;
  logic       data_rdy;
  logic       parity_err;
  logic       frame_err;

  ps2_receiver #(
    .SYNC_STAGES   (SYNC_STAGES),
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .data      (data),
    .data_rdy  (data_rdy),
    .parity_err(parity_err),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Frame-level model
  // ---------------------------------------------------------------------------
  typedef enum int {EV_GOOD, EV_PERR, EV_FERR} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    logic [7:0] value;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] good_log[$];
  logic [7:0] exp_data = 8'h00;

  int checks   = 0;
  int passed   = 0;
  int cyc      = 0;
  int rdy_cnt  = 0;
  int perr_cnt = 0;
  int ferr_cnt = 0;
  int last_fall_cyc = 0;
  int ferr_cyc      = 0;
  logic prev_any = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // A frame is good only with stop = 1 and an odd count of ones over
  // data+parity; a low stop bit is reported as a framing error first.
  function automatic ev_t predict(input logic [7:0] b, input logic par, input logic stop);
    ev_t e;
    e.value = b;
    if (!stop)            e.kind = EV_FERR;
    else if ((^b) ^ par)  e.kind = EV_GOOD;
    else                  e.kind = EV_PERR;
    return e;
  endfunction

  // Compare process: every cycle out of reset, data must equal the model, and
  // any strobe must be a single-cycle, one-hot match for the next prediction.
  always @(negedge clk) begin : compare
    logic [2:0] seen;
    logic [2:0] want;
    ev_t        e;
    if (reset) begin
      exp_data = 8'h00;
      exp_q.delete();
      prev_any = 1'b0;
    end else begin
      seen = {data_rdy, parity_err, frame_err};
      if (seen != 3'b000) begin
        check("strobe_single_cycle", 32'(prev_any), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 32'(seen), 32'd0);
        end else begin
          e = exp_q.pop_front();
          want = (e.kind == EV_GOOD) ? 3'b100 :
                 (e.kind == EV_PERR) ? 3'b010 : 3'b001;
          check("strobe_kind", 32'(seen), 32'(want));
          if (e.kind == EV_GOOD) exp_data = e.value;
        end
        if (data_rdy) begin
          rdy_cnt++;
          good_log.push_back(data);
        end
        if (parity_err) perr_cnt++;
        if (frame_err) begin
          ferr_cnt++;
          ferr_cyc = cyc;
        end
      end
      check("data_value", 32'(data), 32'(exp_data));
      prev_any = |seen;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive bits[0..n-1] as a device would: data changes while the clock is
  // high, the host samples on the falling edge. The glitch variant adds a
  // FILTER_LEN-2 low pulse mid-bit and 1-cycle spikes around both edges.
  task automatic send_bits(input logic [10:0] bits, input int n, input bit glitch);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      if (glitch) begin
        wait_cyc(15);
        ps2_clk = 1'b0; wait_cyc(FILTER_LEN - 2);
        ps2_clk = 1'b1; wait_cyc(16);
        ps2_clk = 1'b0; wait_cyc(1);
        ps2_clk = 1'b1; wait_cyc(2);
      end else begin
        wait_cyc(HALF);
      end
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      if (glitch) begin
        wait_cyc(3);
        ps2_clk = 1'b1; wait_cyc(1);
        ps2_clk = 1'b0; wait_cyc(HALF - 4);
      end else begin
        wait_cyc(HALF);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                            input bit glitch);
    exp_q.push_back(predict(b, par, stop));
    send_bits({stop, par, b, 1'b0}, 11, glitch);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  int r0, p0, f0, delay;

  initial begin : main
    reset = 1'b1;
    wait_cyc(4);
    check("reset_data",       32'(data),       32'h00);
    check("reset_data_rdy",   32'(data_rdy),   32'd0);
    check("reset_parity_err", 32'(parity_err), 32'd0);
    check("reset_frame_err",  32'(frame_err),  32'd0);
    wait_cyc(1);
    #2 reset = 1'b0;
    wait_cyc(HALF);

    // 1: 0x1C has three ones, so odd parity needs parity bit 0.
    r0 = rdy_cnt; p0 = perr_cnt; f0 = ferr_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    wait_drain();
    check("t1_data",     32'(data),               32'h1C);
    check("t1_rdy_cnt",  32'(rdy_cnt - r0),       32'd1);
    check("t1_err_cnt",  32'(perr_cnt + ferr_cnt - p0 - f0), 32'd0);

    // 2: 0xF0 (four ones, parity 1) then 0x1C with no idle gap.
    r0 = rdy_cnt;
    send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    wait_drain();
    check("t2_rdy_cnt",  32'(rdy_cnt - r0), 32'd2);
    check("t2_first",    32'(good_log[good_log.size() - 2]), 32'hF0);
    check("t2_second",   32'(good_log[good_log.size() - 1]), 32'h1C);
    check("t2_data",     32'(data), 32'h1C);

    // 3: 0x5A has four ones, so parity bit 0 makes the total even: reject.
    r0 = rdy_cnt; p0 = perr_cnt;
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    wait_drain();
    check("t3_perr_cnt", 32'(perr_cnt - p0), 32'd1);
    check("t3_rdy_cnt",  32'(rdy_cnt - r0),  32'd0);
    check("t3_data",     32'(data),          32'h1C);

    // 4: 0x29 with a low stop bit, then a clean 0x29 (three ones, parity 0).
    r0 = rdy_cnt; f0 = ferr_cnt;
    send_frame(8'h29, 1'b0, 1'b0, 1'b0);
    wait_drain();
    check("t4_ferr_cnt", 32'(ferr_cnt - f0), 32'd1);
    check("t4_rdy_cnt",  32'(rdy_cnt - r0),  32'd0);
    check("t4_data_hold", 32'(data),         32'h1C);
    send_frame(8'h29, 1'b0, 1'b1, 1'b0);
    wait_drain();
    check("t4_data",     32'(data), 32'h29);

    // 5: 0x16 (three ones, parity 0) with clock glitches on every bit.
    r0 = rdy_cnt; p0 = perr_cnt; f0 = ferr_cnt;
    send_frame(8'h16, 1'b0, 1'b1, 1'b1);
    wait_drain();
    check("t5_data",     32'(data),               32'h16);
    check("t5_rdy_cnt",  32'(rdy_cnt - r0),       32'd1);
    check("t5_err_cnt",  32'(perr_cnt + ferr_cnt - p0 - f0), 32'd0);
    wait_cyc(HALF);

`ifdef PS2_TIMEOUT_EN
    // 6a: start plus four data bits of 0x29, then the clock stays high.
    r0 = rdy_cnt; f0 = ferr_cnt;
    exp_q.push_back('{kind: EV_FERR, value: 8'h00});
    send_bits({2'b11, 8'h29, 1'b0}, 5, 1'b0);
    for (int i = 0; i < TB_TIMEOUT + 100 && ferr_cnt == f0; i++) @(negedge clk);
    check("t6_ferr_cnt", 32'(ferr_cnt - f0), 32'd1);
    // From the raw falling edge: SYNC_STAGES + FILTER_LEN cycles to reach the
    // filtered edge, then TIMEOUT_CYCLES, with a small allowance either side.
    delay = ferr_cyc - last_fall_cyc;
    check("t6_timeout_delay_in_window",
          32'((delay >= TB_TIMEOUT + SYNC_STAGES + FILTER_LEN - 2) &&
              (delay <= TB_TIMEOUT + SYNC_STAGES + FILTER_LEN + 2)), 32'd1);
    check("t6_rdy_cnt",  32'(rdy_cnt - r0), 32'd0);
    check("t6_data_hold", 32'(data), 32'h16);
    wait_drain();
    send_frame(8'h29, 1'b0, 1'b1, 1'b0);
    wait_drain();
    check("t6_data",     32'(data), 32'h29);
    wait_cyc(HALF);
`endif

    // 7: asynchronous reset in the middle of a frame, then a clean frame.
    send_bits({2'b11, 8'h5A, 1'b0}, 4, 1'b0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("t7_async_data",       32'(data),       32'h00);
    check("t7_async_data_rdy",   32'(data_rdy),   32'd0);
    check("t7_async_parity_err", 32'(parity_err), 32'd0);
    check("t7_async_frame_err",  32'(frame_err),  32'd0);
    wait_cyc(3);
    #2 reset = 1'b0;
    wait_cyc(HALF);
    r0 = rdy_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    wait_drain();
    check("t7_data",     32'(data), 32'h1C);
    check("t7_rdy_cnt",  32'(rdy_cnt - r0), 32'd1);

    wait_cyc(10);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Upper bound on run time so a stuck DUT cannot hang the bench.
  initial begin : watchdog
    #(10 * 60000);
    $display("FAIL watchdog: simulation exceeded 60000 clk cycles");
    $fatal(1, "time limit reached");
  end

endmodule
